// File: rtl/mips_bus_pkg.sv
// Shared types for the memory bus arbiter: FSM states, bus owner and the full-word byte mask.
package mips_bus_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} arb_state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_D, OWN_I} owner_t;

  localparam logic [3:0] SEL_WORD = 4'b1111;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Counts busy cycles of a bus transaction and flags the cycle on which the limit is reached.
module bus_timeout_cnt #(
  parameter int unsigned Width = 8,
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [Width-1:0] Last = Width'(Limit - 1);

  logic [Width-1:0] count_q, count_d;

  // Saturate at the last value so a held expire cannot wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != Last)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = enable && (count_q == Last);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone-style port between instruction fetch (I) and data (D) clients, D first.
// Optional busy-cycle abort is enabled by defining MEM_BUS_ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned N_ADDR      = 32,
  parameter int unsigned N_DATA      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pipe_stall,
  input  logic              i_flush,
  input  logic              i_d_ce,
  input  logic              i_d_we,
  input  logic [3:0]        i_d_sel,
  input  logic [N_ADDR-1:0] i_d_addr,
  input  logic [N_DATA-1:0] i_d_wdata,
  output logic [N_DATA-1:0] o_d_rdata,
  output logic              o_d_stall,
  input  logic              i_i_ce,
  input  logic [N_ADDR-1:0] i_i_addr,
  output logic [N_DATA-1:0] o_i_rdata,
  output logic              o_i_stall,
  output logic              o_bus_cyc,
  output logic              o_bus_stb,
  output logic              o_bus_we,
  output logic [3:0]        o_bus_sel,
  output logic [N_ADDR-1:0] o_bus_adr,
  output logic [N_DATA-1:0] o_bus_dat,
  input  logic              i_bus_ack,
  input  logic [N_DATA-1:0] i_bus_dat,
  output logic              o_bus_err
);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              drop_q, drop_d;
  logic [N_DATA-1:0] hold_q, hold_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [N_ADDR-1:0] adr_q, adr_d;
  logic [N_DATA-1:0] dat_q, dat_d;

  logic              timeout_hit;
  logic              done;
  logic              kill;
  logic [N_DATA-1:0] result;
  logic              served;
  logic [N_DATA-1:0] data_out;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic expire;

  bus_timeout_cnt #(
    .Width(CntW),
    .Limit(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (state_q != BUSY),
    .enable(state_q == BUSY),
    .expire(expire)
  );

  // A real ack on the limit cycle wins over the abort.
  assign timeout_hit = expire && !i_bus_ack;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
`endif

  assign done   = (state_q == BUSY) && (i_bus_ack || timeout_hit);
  assign kill   = drop_q || i_flush;
  // Writes, flushed transactions and aborts hand back zero instead of bus data.
  assign result = (kill || we_q || timeout_hit) ? '0 : i_bus_dat;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    hold_d  = hold_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (!i_flush && i_d_ce) begin
          state_d = BUSY;
          owner_d = OWN_D;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = i_d_we;
          sel_d   = i_d_sel;
          adr_d   = i_d_addr;
          dat_d   = i_d_wdata;
        end else if (!i_flush && i_i_ce) begin
          state_d = BUSY;
          owner_d = OWN_I;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = SEL_WORD;
          adr_d   = i_i_addr;
          dat_d   = '0;
        end
      end
      BUSY: begin
        if (done) begin
          cyc_d  = 1'b0;
          stb_d  = 1'b0;
          we_d   = 1'b0;
          sel_d  = '0;
          adr_d  = '0;
          dat_d  = '0;
          hold_d = result;
          drop_d = 1'b0;
          if (!kill && i_pipe_stall) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
            owner_d = OWN_NONE;
          end
        end else if (i_flush) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (!i_pipe_stall || i_flush) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      drop_q  <= 1'b0;
      hold_q  <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      hold_q  <= hold_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign served   = done || (state_q == HOLD);
  assign data_out = (state_q == HOLD) ? hold_q : result;

  assign o_d_rdata = ((owner_q == OWN_D) && served) ? data_out : '0;
  assign o_i_rdata = ((owner_q == OWN_I) && served) ? data_out : '0;
  // Stalls follow ce combinationally, so reset gates them to keep every output low.
  assign o_d_stall = i_d_ce && !((owner_q == OWN_D) && served) && !i_flush && !i_rst;
  assign o_i_stall = i_i_ce && !((owner_q == OWN_I) && served) && !i_flush && !i_rst;

  assign o_bus_cyc = cyc_q;
  assign o_bus_stb = stb_q;
  assign o_bus_we  = we_q;
  assign o_bus_sel = sel_q;
  assign o_bus_adr = adr_q;
  assign o_bus_dat = dat_q;
  assign o_bus_err = timeout_hit;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, reset/timeout sequences, random vs model.
module tb_mem_bus_arbiter;

  localparam int unsigned TO = 4;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_pipe_stall, i_flush;
  logic        i_d_ce, i_d_we;
  logic [3:0]  i_d_sel;
  logic [31:0] i_d_addr, i_d_wdata, o_d_rdata;
  logic        o_d_stall;
  logic        i_i_ce;
  logic [31:0] i_i_addr, o_i_rdata;
  logic        o_i_stall;
  logic        o_bus_cyc, o_bus_stb, o_bus_we;
  logic [3:0]  o_bus_sel;
  logic [31:0] o_bus_adr, o_bus_dat;
  logic        i_bus_ack;
  logic [31:0] i_bus_dat;
  logic        o_bus_err;

  always #5 i_clk = ~i_clk;

  mem_bus_arbiter #(
    .N_ADDR     (32),
    .N_DATA     (32),
    .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_pipe_stall(i_pipe_stall),
    .i_flush     (i_flush),
    .i_d_ce      (i_d_ce),
    .i_d_we      (i_d_we),
    .i_d_sel     (i_d_sel),
    .i_d_addr    (i_d_addr),
    .i_d_wdata   (i_d_wdata),
    .o_d_rdata   (o_d_rdata),
    .o_d_stall   (o_d_stall),
    .i_i_ce      (i_i_ce),
    .i_i_addr    (i_i_addr),
    .o_i_rdata   (o_i_rdata),
    .o_i_stall   (o_i_stall),
    .o_bus_cyc   (o_bus_cyc),
    .o_bus_stb   (o_bus_stb),
    .o_bus_we    (o_bus_we),
    .o_bus_sel   (o_bus_sel),
    .o_bus_adr   (o_bus_adr),
    .o_bus_dat   (o_bus_dat),
    .i_bus_ack   (i_bus_ack),
    .i_bus_dat   (i_bus_dat),
    .o_bus_err   (o_bus_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // {cyc, stb, we, sel, adr, dat, err, d_rdata, d_stall, i_rdata, i_stall}
  typedef logic [137:0] obs_t;

  function automatic obs_t observe();
    return {o_bus_cyc, o_bus_stb, o_bus_we, o_bus_sel, o_bus_adr, o_bus_dat, o_bus_err,
            o_d_rdata, o_d_stall, o_i_rdata, o_i_stall};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_pipe_stall = 0; i_flush = 0;
    i_d_ce = 0; i_d_we = 0; i_d_sel = 0; i_d_addr = 0; i_d_wdata = 0;
    i_i_ce = 0; i_i_addr = 0; i_bus_ack = 0; i_bus_dat = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst = 1;
    @(posedge i_clk); #1;
    i_rst = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        d_ce, d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr, d_wdata;
    logic        i_ce;
    logic [31:0] i_addr;
    logic        ack;
    logic [31:0] bdat;
    logic        pst, fl;
    logic        e_cyc, e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_adr, e_dat, e_drd;
    logic        e_dst;
    logic [31:0] e_ird;
    logic        e_ist;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic d_ce, d_we, input logic [3:0] d_sel,
                     input logic [31:0] d_addr, d_wdata, input logic i_ce,
                     input logic [31:0] i_addr, input logic ack, input logic [31:0] bdat,
                     input logic pst, fl,
                     input logic e_cyc, e_we, input logic [3:0] e_sel,
                     input logic [31:0] e_adr, e_dat, e_drd, input logic e_dst,
                     input logic [31:0] e_ird, input logic e_ist);
    vec_t v;
    v.d_ce = d_ce; v.d_we = d_we; v.d_sel = d_sel; v.d_addr = d_addr; v.d_wdata = d_wdata;
    v.i_ce = i_ce; v.i_addr = i_addr; v.ack = ack; v.bdat = bdat; v.pst = pst; v.fl = fl;
    v.e_cyc = e_cyc; v.e_we = e_we; v.e_sel = e_sel; v.e_adr = e_adr; v.e_dat = e_dat;
    v.e_drd = e_drd; v.e_dst = e_dst; v.e_ird = e_ird; v.e_ist = e_ist;
    tbl.push_back(v);
  endtask

  task automatic fill_table();
    // D read, ack on second stb cycle
    add(1,0,4'hF,32'h100,0, 0,0, 0,0, 0,0,  0,0,4'h0,0,0, 0,1, 0,0);
    add(1,0,4'hF,32'h100,0, 0,0, 0,0, 0,0,  1,0,4'hF,32'h100,0, 0,1, 0,0);
    add(1,0,4'hF,32'h100,0, 0,0, 1,32'hDEADBEEF, 0,0,
        1,0,4'hF,32'h100,0, 32'hDEADBEEF,0, 0,0);
    add(0,0,0,0,0, 0,0, 0,0, 0,0,  0,0,0,0,0, 0,0, 0,0);
    // D write and I fetch together: D wins, I waits
    add(1,1,4'h3,32'h200,32'h12345678, 1,32'h40, 0,0, 0,0,  0,0,0,0,0, 0,1, 0,1);
    add(1,1,4'h3,32'h200,32'h12345678, 1,32'h40, 1,32'hFFFFFFFF, 0,0,
        1,1,4'h3,32'h200,32'h12345678, 0,0, 0,1);
    add(0,0,0,0,0, 1,32'h40, 0,0, 0,0,  0,0,0,0,0, 0,0, 0,1);
    add(0,0,0,0,0, 1,32'h40, 1,32'h0BADF00D, 0,0,
        1,0,4'hF,32'h40,0, 0,0, 32'h0BADF00D,0);
    add(0,0,0,0,0, 0,0, 0,0, 0,0,  0,0,0,0,0, 0,0, 0,0);
    // I fetch acked under pipeline stall: held result, no new grant
    add(0,0,0,0,0, 1,32'h80, 0,0, 0,0,  0,0,0,0,0, 0,0, 0,1);
    add(0,0,0,0,0, 1,32'h80, 1,32'hA5A5A5A5, 1,0,
        1,0,4'hF,32'h80,0, 0,0, 32'hA5A5A5A5,0);
    add(1,0,4'hF,32'h300,0, 1,32'h80, 0,0, 1,0,  0,0,0,0,0, 0,1, 32'hA5A5A5A5,0);
    add(1,0,4'hF,32'h300,0, 1,32'h80, 0,0, 1,0,  0,0,0,0,0, 0,1, 32'hA5A5A5A5,0);
    add(1,0,4'hF,32'h300,0, 0,0, 0,0, 0,0,  0,0,0,0,0, 0,1, 32'hA5A5A5A5,0);
    add(1,0,4'hF,32'h300,0, 0,0, 0,0, 0,0,  0,0,0,0,0, 0,1, 0,0);
    add(1,0,4'hF,32'h300,0, 0,0, 1,32'h11112222, 0,0,
        1,0,4'hF,32'h300,0, 32'h11112222,0, 0,0);
    add(0,0,0,0,0, 0,0, 0,0, 0,0,  0,0,0,0,0, 0,0, 0,0);
    // flush while busy: bus runs to ack, data dropped, IDLE even under stall
    add(1,0,4'hF,32'h400,0, 0,0, 0,0, 0,0,  0,0,0,0,0, 0,1, 0,0);
    add(1,0,4'hF,32'h400,0, 0,0, 0,0, 0,1,  1,0,4'hF,32'h400,0, 0,0, 0,0);
    add(0,0,0,0,0, 0,0, 0,0, 0,0,  1,0,4'hF,32'h400,0, 0,0, 0,0);
    add(0,0,0,0,0, 0,0, 1,32'hCAFECAFE, 1,0,  1,0,4'hF,32'h400,0, 0,0, 0,0);
    add(0,0,0,0,0, 1,32'h44, 0,0, 0,0,  0,0,0,0,0, 0,0, 0,1);
    add(0,0,0,0,0, 1,32'h44, 0,0, 0,0,  1,0,4'hF,32'h44,0, 0,0, 0,1);
    add(0,0,0,0,0, 1,32'h44, 1,32'h77, 0,0,  1,0,4'hF,32'h44,0, 0,0, 32'h77,0);
    // stray acks while idle
    add(0,0,0,0,0, 0,0, 1,32'h55, 0,0,  0,0,0,0,0, 0,0, 0,0);
    add(0,0,0,0,0, 0,0, 1,32'h66, 0,0,  0,0,0,0,0, 0,0, 0,0);
  endtask

  // ---------------- reference model ----------------
  bit          m_busy, m_hold, m_kill, m_we;
  int          m_who;   // 0 none, 1 D, 2 I
  int          m_cnt;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_dat, m_held;

  task automatic model_reset();
    m_busy = 0; m_hold = 0; m_kill = 0; m_we = 0; m_who = 0; m_cnt = 0;
    m_sel = 0; m_adr = 0; m_dat = 0; m_held = 0;
  endtask

  function automatic bit m_timeout();
    return m_busy && !i_bus_ack && TO_EN && (m_cnt == int'(TO) - 1);
  endfunction

  function automatic logic [31:0] m_result();
    return (m_kill || i_flush || m_we || m_timeout()) ? 32'h0 : i_bus_dat;
  endfunction

  function automatic obs_t model_out();
    bit          fin;
    logic [31:0] drd, ird;
    logic        dst, ist;
    fin = m_busy && (i_bus_ack || m_timeout());
    drd = (m_who == 1 && fin) ? m_result() : (m_who == 1 && m_hold) ? m_held : 32'h0;
    ird = (m_who == 2 && fin) ? m_result() : (m_who == 2 && m_hold) ? m_held : 32'h0;
    dst = i_d_ce && !i_flush && !(m_who == 1 && (fin || m_hold));
    ist = i_i_ce && !i_flush && !(m_who == 2 && (fin || m_hold));
    return {m_busy, m_busy, m_we, m_sel, m_adr, m_dat, m_timeout(), drd, dst, ird, ist};
  endfunction

  task automatic model_step();
    bit          fin, killed;
    logic [31:0] res;
    if (m_busy) begin
      fin = i_bus_ack || m_timeout();
      res = m_result();
      if (fin) begin
        killed = m_kill || i_flush;
        m_busy = 0; m_we = 0; m_sel = 0; m_adr = 0; m_dat = 0; m_cnt = 0; m_kill = 0;
        if (!killed && i_pipe_stall) begin
          m_hold = 1;
          m_held = res;
        end else begin
          m_who = 0;
        end
      end else begin
        m_cnt++;
        if (i_flush) m_kill = 1;
      end
    end else if (m_hold) begin
      if (!i_pipe_stall || i_flush) begin
        m_hold = 0;
        m_who  = 0;
      end
    end else if (!i_flush) begin
      if (i_d_ce) begin
        m_busy = 1; m_who = 1; m_we = i_d_we; m_sel = i_d_sel;
        m_adr = i_d_addr; m_dat = i_d_wdata;
      end else if (i_i_ce) begin
        m_busy = 1; m_who = 2; m_we = 0; m_sel = 4'hF; m_adr = i_i_addr; m_dat = 0;
      end
    end
  endtask

  // ---------------- main ----------------
  initial begin
    idle_inputs();
    i_rst = 1;
    @(negedge i_clk);
    check("reset_state", observe(), '0);
    @(posedge i_clk); #1;
    i_rst = 0;

    fill_table();
    foreach (tbl[k]) begin
      i_d_ce = tbl[k].d_ce; i_d_we = tbl[k].d_we; i_d_sel = tbl[k].d_sel;
      i_d_addr = tbl[k].d_addr; i_d_wdata = tbl[k].d_wdata;
      i_i_ce = tbl[k].i_ce; i_i_addr = tbl[k].i_addr;
      i_bus_ack = tbl[k].ack; i_bus_dat = tbl[k].bdat;
      i_pipe_stall = tbl[k].pst; i_flush = tbl[k].fl;
      @(negedge i_clk);
      check($sformatf("vec%0d", k), observe(),
            {tbl[k].e_cyc, tbl[k].e_cyc, tbl[k].e_we, tbl[k].e_sel, tbl[k].e_adr,
             tbl[k].e_dat, 1'b0, tbl[k].e_drd, tbl[k].e_dst, tbl[k].e_ird, tbl[k].e_ist});
      @(posedge i_clk); #1;
    end

    // async reset in the middle of a D transaction
    idle_inputs();
    i_d_ce = 1; i_d_sel = 4'hF; i_d_addr = 32'h500;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("busy_before_reset", {o_bus_cyc, o_bus_adr}, {1'b1, 32'h500});
    #1 i_rst = 1;
    #1 check("async_reset_outputs", observe(), '0);
    @(posedge i_clk); #1;
    i_rst = 0;
    i_d_ce = 1; i_d_we = 1; i_d_sel = 4'h5; i_d_addr = 32'h600; i_d_wdata = 32'h99;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("grant_after_reset", {o_bus_cyc, o_bus_stb, o_bus_we, o_bus_sel, o_bus_adr, o_bus_dat},
          {1'b1, 1'b1, 1'b1, 4'h5, 32'h600, 32'h99});
    i_bus_ack = 1;
    @(posedge i_clk); #1;
    idle_inputs();
    @(posedge i_clk); #1;

    // D read left without ack
    i_d_ce = 1; i_d_sel = 4'hF; i_d_addr = 32'h700;
    @(posedge i_clk); #1;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    for (int k = 1; k <= int'(TO); k++) begin
      @(negedge i_clk);
      check($sformatf("timeout_busy%0d", k), {o_bus_cyc, o_bus_err, o_d_stall, o_d_rdata},
            {1'b1, (k == int'(TO)), (k != int'(TO)), 32'h0});
      @(posedge i_clk); #1;
    end
    i_d_ce = 0;
    @(negedge i_clk);
    check("timeout_after", {o_bus_cyc, o_bus_stb, o_bus_err}, 3'b000);
    @(posedge i_clk); #1;
`else
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      if (k == 1 || k == 20)
        check($sformatf("no_timeout%0d", k), {o_bus_cyc, o_bus_err, o_d_stall}, 3'b101);
      @(posedge i_clk); #1;
    end
    i_bus_ack = 1; i_bus_dat = 32'h1234;
    @(negedge i_clk);
    check("late_ack", {o_bus_cyc, o_d_stall, o_d_rdata}, {1'b1, 1'b0, 32'h1234});
    @(posedge i_clk); #1;
`endif

    // randomized traffic against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      i_d_ce       = ($urandom_range(1, 0) == 1);
      i_d_we       = ($urandom_range(1, 0) == 1);
      i_d_sel      = 4'($urandom_range(15, 0));
      i_d_addr     = $urandom;
      i_d_wdata    = $urandom;
      i_i_ce       = ($urandom_range(1, 0) == 1);
      i_i_addr     = $urandom;
      i_bus_ack    = ($urandom_range(2, 0) == 0);
      i_bus_dat    = $urandom;
      i_pipe_stall = ($urandom_range(2, 0) == 0);
      i_flush      = ($urandom_range(15, 0) == 0);
      @(negedge i_clk);
      check($sformatf("rand%0d", c), observe(), model_out());
      @(posedge i_clk);
      model_step();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
